// File: rtl/cdb_rr_scheduler.sv
`default_nettype none
// ============================================================================
// cdb_rr_scheduler - round-robin arbiter that shares one CDB slot per cycle.
// Optional macro CDB_LDPRIO_EN: load buffer (index N-1) gets fixed priority.
// Revision 1.0
// ============================================================================
module cdb_rr_scheduler #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  cdb_stall,
  input  logic [N-1:0]          req_valid,
  input  logic [N*TAG_W-1:0]    req_tag,
  input  logic [N*DATA_W-1:0]   req_data,
  output logic [N-1:0]          grant,
  output logic                  cdb_valid,
  output logic [TAG_W-1:0]      cdb_tag,
  output logic [DATA_W-1:0]     cdb_data,
  output logic [$clog2(N)-1:0]  rr_ptr,
  output logic [CNT_W-1:0]      bcast_count
);

  localparam int PTR_W = $clog2(N);
`ifdef CDB_LDPRIO_EN
  localparam int RR_N = N - 1;
`else
  localparam int RR_N = N;
`endif
  localparam logic [PTR_W-1:0] LAST_RR = PTR_W'(RR_N - 1);
  localparam logic [PTR_W-1:0] LD_IDX  = PTR_W'(N - 1);

  logic             found;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] idx;
  logic             take;
  logic [PTR_W-1:0] ptr_nxt;
  logic [TAG_W-1:0] sel_tag;
  logic [DATA_W-1:0] sel_data;

  // Winner search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
`ifdef CDB_LDPRIO_EN
    if (req_valid[N-1]) begin
      found = 1'b1;
      win   = LD_IDX;
    end
`endif
    for (int k = 0; k < RR_N; k++) begin
      idx = PTR_W'((int'(rr_ptr) + k) % RR_N);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign take    = found & ~reset & ~flush & ~cdb_stall;
  assign ptr_nxt = (win == LAST_RR) ? '0 : win + 1'b1;

  always_comb begin
    grant    = '0;
    sel_tag  = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (take && win == PTR_W'(i)) begin
        grant[i] = 1'b1;
        sel_tag  = req_tag[i*TAG_W +: TAG_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cdb_valid   <= 1'b0;
      cdb_tag     <= '0;
      cdb_data    <= '0;
      rr_ptr      <= '0;
      bcast_count <= '0;
    end else begin
      cdb_valid <= take;
      if (take) begin
        cdb_tag  <= sel_tag;
        cdb_data <= sel_data;
`ifdef CDB_LDPRIO_EN
        // Priority grants to the load buffer leave the rotation untouched.
        if (win != LD_IDX) rr_ptr <= ptr_nxt;
`else
        rr_ptr <= ptr_nxt;
`endif
        if (bcast_count != {CNT_W{1'b1}}) bcast_count <= bcast_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
